jtag_host: RTL and testbench

- Initiator (host) side of the JTAG interface that ACoreChip exposes as a TAP target.
- Generates TCK/TMS/TDI, samples TDO, and walks the IEEE 1149.1 TAP state machine.
- Executes one IR or DR scan of up to 32 bits per command and returns the captured TDO bits.
- Used for on-board self-test and for bridging a host link, such as UART, to the core's debug module.

---
 rtl/jtag_host_pkg.sv | 29 ++
 rtl/jtag_tck_gen.sv | 57 +++++
 rtl/jtag_host.sv | 218 +++++++++++++++++++++
 tb/tb_jtag_host.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared types and TMS patterns for the JTAG host.
// Patterns are stored LSB first: bit k is the TMS value of pulse k.
package jtag_host_pkg;
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_HEAD,
        ST_SHIFT,
        ST_TAIL,
        ST_RESP
    } jtag_state_t;

    localparam int LEN_W = 6;

    localparam logic [5:0] TAP_RESET_TMS = 6'b011111;
    localparam logic [2:0] DR_HEAD_TMS   = 3'b001;
    localparam logic [3:0] IR_HEAD_TMS   = 4'b0011;
    localparam logic [1:0] TAIL_TMS      = 2'b01;

    localparam logic [LEN_W-1:0] RESET_LEN   = 6'd6;
    localparam logic [LEN_W-1:0] DR_HEAD_LEN = 6'd3;
    localparam logic [LEN_W-1:0] IR_HEAD_LEN = 6'd4;
    localparam logic [LEN_W-1:0] TAIL_LEN    = 6'd2;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// Emits one TCK pulse per start: CLK_DIV cycles low, CLK_DIV cycles high.
// o_done marks the final high cycle so a new start there produces no gap.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_start,
    input  logic i_tms,
    input  logic i_tdi,
    input  logic i_tdo,
    output logic o_tck,
    output logic o_tms,
    output logic o_tdi,
    output logic o_tdo,
    output logic o_done
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_done = r_busy && o_tck && w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            o_tck  <= 1'b0;
            o_tms  <= 1'b1;
            o_tdi  <= 1'b0;
            o_tdo  <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            o_tck  <= 1'b0;
            o_tms  <= i_tms;
            o_tdi  <= i_tdi;
        end else if (r_busy) begin
            if (w_last) begin
                r_cnt <= '0;
                // TDO is captured on the same edge that raises TCK.
                if (!o_tck) begin
                    o_tck <= 1'b1;
                    o_tdo <= i_tdo;
                end else begin
                    o_tck  <= 1'b0;
                    r_busy <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/jtag_host.sv
// JTAG TAP initiator: runs one IR or DR scan (or a TAP reset) per command
// and returns the TDO bits captured during the shift phase.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_ir,
    input  logic               i_cmd_reset,
    input  logic [LEN_W-1:0]   i_cmd_len,
    input  logic [MAX_LEN-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [MAX_LEN-1:0] o_rsp_data,
    output logic               o_tck,
    output logic               o_tms,
    output logic               o_tdi,
    input  logic               i_tdo,
    output logic               o_trstn,
    output jtag_state_t        o_dbg_state
);
    localparam int               IDX_W     = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    jtag_state_t        r_state;
    logic [LEN_W-1:0]   r_bit;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cap_idx;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap_data;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               r_ir;
    logic               r_rst_cmd;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic               r_trstn;
    logic               r_pulse_busy;
    logic               r_cur_shift;

    logic [7:0]         w_pat;
    logic [LEN_W-1:0]   w_phase_len;
    logic [LEN_W-1:0]   w_len_in;
    logic               w_emit;
    logic               w_tms;
    logic               w_tdi;
    logic               w_tdo;
    logic               w_done;
    logic               w_start;
    logic               w_last_issue;
    logic               w_final;

    // Pulse source for the current phase: pattern, length and TDI bit.
    always_comb begin
        w_pat       = '0;
        w_phase_len = '0;
        w_emit      = 1'b0;
        w_tdi       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_emit      = 1'b1;
                w_phase_len = RESET_LEN;
                w_pat       = {2'b00, TAP_RESET_TMS};
            end
            ST_HEAD: begin
                w_emit = 1'b1;
                if (r_rst_cmd) begin
                    w_phase_len = RESET_LEN;
                    w_pat       = {2'b00, TAP_RESET_TMS};
                end else if (r_ir) begin
                    w_phase_len = IR_HEAD_LEN;
                    w_pat       = {4'b0000, IR_HEAD_TMS};
                end else begin
                    w_phase_len = DR_HEAD_LEN;
                    w_pat       = {5'b00000, DR_HEAD_TMS};
                end
            end
            ST_SHIFT: begin
                w_emit      = 1'b1;
                w_phase_len = r_len;
                w_tdi       = r_data[r_bit[IDX_W-1:0]];
            end
            ST_TAIL: begin
                w_emit      = 1'b1;
                w_phase_len = TAIL_LEN;
                w_pat       = {6'b000000, TAIL_TMS};
            end
            default: ;
        endcase
        w_tms = (r_state == ST_SHIFT) ? (r_bit == r_len - LEN_W'(1)) : w_pat[r_bit[2:0]];
    end

    // A new pulse may start when the generator is idle or on its last cycle.
    assign w_start      = w_emit && (!r_pulse_busy || w_done) && (r_bit < w_phase_len);
    assign w_last_issue = w_start && (r_bit == w_phase_len - LEN_W'(1));
    assign w_final      = w_done && (r_bit == w_phase_len);
    assign w_len_in     = clamp_len(i_cmd_len, MAX_LEN_L);

    // Both ports use valid/ready: a transfer happens on a cycle where valid and
    // ready are both high; the initiator holds its payload until then.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_bit        <= '0;
            r_len        <= '0;
            r_cap_idx    <= '0;
            r_data       <= '0;
            r_cap_data   <= '0;
            r_rsp_data   <= '0;
            r_ir         <= 1'b0;
            r_rst_cmd    <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_trstn      <= 1'b0;
            r_pulse_busy <= 1'b0;
            r_cur_shift  <= 1'b0;
        end else begin
            r_trstn <= 1'b1;
            if (w_start) begin
                r_bit        <= r_bit + LEN_W'(1);
                r_pulse_busy <= 1'b1;
                r_cur_shift  <= (r_state == ST_SHIFT);
            end else if (w_done) begin
                r_pulse_busy <= 1'b0;
            end
            if (w_done && r_cur_shift) begin
                r_cap_data[r_cap_idx[IDX_W-1:0]] <= w_tdo;
                r_cap_idx <= r_cap_idx + LEN_W'(1);
            end
            case (r_state)
                ST_INIT: begin
                    if (w_final) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_ir        <= i_cmd_ir;
                        r_rst_cmd   <= i_cmd_reset;
                        r_len       <= w_len_in;
                        r_data      <= i_cmd_data;
                        r_bit       <= '0;
                        r_cap_idx   <= '0;
                        r_cap_data  <= '0;
                        if (!i_cmd_reset && (w_len_in == '0)) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_state <= ST_HEAD;
                        end
                    end
                end
                ST_HEAD: begin
                    if (r_rst_cmd) begin
                        if (w_final) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                        end
                    end else if (w_last_issue) begin
                        r_state <= ST_SHIFT;
                        r_bit   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_issue) begin
                        r_state <= ST_TAIL;
                        r_bit   <= '0;
                    end
                end
                ST_TAIL: begin
                    if (w_final) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cap_data;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clock  (clock),
        .reset  (reset),
        .i_start(w_start),
        .i_tms  (w_tms),
        .i_tdi  (w_tdi),
        .i_tdo  (i_tdo),
        .o_tck  (o_tck),
        .o_tms  (o_tms),
        .o_tdi  (o_tdi),
        .o_tdo  (w_tdo),
        .o_done (w_done)
    );

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_trstn     = r_trstn;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a TAP target model on the JTAG pins, a response
// scoreboard, and per-scan checks of the TCK pulse count, TMS and TDI streams.
module tb_jtag_host;
    import jtag_host_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int BIT_CYC = 2 * CLK_DIV;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6, EX2DR = 7;
    localparam int UPDDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPDIR = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_ir = 1'b0;
    logic        i_cmd_reset = 1'b0;
    logic [5:0]  i_cmd_len = '0;
    logic [31:0] i_cmd_data = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic        o_tck;
    logic        o_tms;
    logic        o_tdi;
    logic        i_tdo;
    logic        o_trstn;
    jtag_state_t o_dbg_state;

    jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_ir   (i_cmd_ir),
        .i_cmd_reset(i_cmd_reset),
        .i_cmd_len  (i_cmd_len),
        .i_cmd_data (i_cmd_data),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data (o_rsp_data),
        .o_tck      (o_tck),
        .o_tms      (o_tms),
        .o_tdi      (o_tdi),
        .i_tdo      (i_tdo),
        .o_trstn    (o_trstn),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // ---------------- TAP target model ----------------
    int          tap_st = TLR;
    logic [4:0]  ir_sr = '0;
    logic [4:0]  ir_cap = 5'b00001;
    logic        tms_q[$];
    logic        tdi_q[$];
    int          rise_q[$];
    int          fall_q[$];

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:     return tms ? TLR   : RTI;
            RTI:     return tms ? SELDR : RTI;
            SELDR:   return tms ? SELIR : CAPDR;
            CAPDR:   return tms ? EX1DR : SHDR;
            SHDR:    return tms ? EX1DR : SHDR;
            EX1DR:   return tms ? UPDDR : PAUDR;
            PAUDR:   return tms ? EX2DR : PAUDR;
            EX2DR:   return tms ? UPDDR : SHDR;
            UPDDR:   return tms ? SELDR : RTI;
            SELIR:   return tms ? TLR   : CAPIR;
            CAPIR:   return tms ? EX1IR : SHIR;
            SHIR:    return tms ? EX1IR : SHIR;
            EX1IR:   return tms ? UPDIR : PAUIR;
            PAUIR:   return tms ? EX2IR : PAUIR;
            EX2IR:   return tms ? UPDIR : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge o_tck or negedge o_trstn) begin
        if (!o_trstn) begin
            tap_st <= TLR;
        end else begin
            tms_q.push_back(o_tms);
            tdi_q.push_back(o_tdi);
            rise_q.push_back(cyc);
            if (tap_st == CAPIR) ir_sr <= ir_cap;
            else if (tap_st == SHIR) ir_sr <= {o_tdi, ir_sr[4:1]};
            tap_st <= tap_next(tap_st, o_tms);
        end
    end

    always @(negedge o_tck) fall_q.push_back(cyc);

    // DR is a zero-latency loopback; IR presents its captured/shifted bit.
    assign i_tdo = (tap_st == SHDR) ? o_tdi : ((tap_st == SHIR) ? ir_sr[0] : 1'b0);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_bits(input bit sel_tdi, input int from);
        logic [63:0] v;
        v = '0;
        for (int i = from; i < tms_q.size() && (i - from) < 64; i++)
            v[i - from] = sel_tdi ? tdi_q[i] : tms_q[i];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 2000 && !o_cmd_ready; i++) step();
        chk(tag, o_cmd_ready, 1);
    endtask

    task automatic check_init(input string tag, input int t0, input int f0);
        logic [63:0] etms;
        etms = '0;
        for (int i = 0; i < 5; i++) etms[i] = 1'b1;
        chk({tag, "_pulses"}, tms_q.size() - t0, 6);
        chk({tag, "_tms"}, pack_bits(1'b0, t0), etms);
        chk({tag, "_tdi"}, pack_bits(1'b1, t0), 0);
        if (tms_q.size() - t0 == 6 && fall_q.size() - f0 >= 6) begin
            for (int i = 1; i < 6; i++)
                chk({tag, "_period"}, rise_q[t0 + i] - rise_q[t0 + i - 1], BIT_CYC);
            for (int i = 0; i < 6; i++)
                chk({tag, "_high"}, fall_q[f0 + i] - rise_q[t0 + i], CLK_DIV);
        end
    endtask

    task automatic run_cmd(input bit ir, input bit rst, input logic [5:0] len,
                           input logic [31:0] data, input bit stall);
        int          eff;
        int          n;
        int          start;
        logic [63:0] etms;
        logic [63:0] etdi;
        logic [31:0] exp;
        logic [31:0] got;
        eff  = (len > 6'd32) ? 32 : int'(len);
        n    = 0;
        etms = '0;
        etdi = '0;
        exp  = '0;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin etms[n] = 1'b1; n++; end
            etms[n] = 1'b0; n++;
        end else if (eff > 0) begin
            etms[n] = 1'b1; n++;
            if (ir) begin etms[n] = 1'b1; n++; end
            etms[n] = 1'b0; n++;
            etms[n] = 1'b0; n++;
            for (int k = 0; k < eff; k++) begin
                etdi[n] = data[k];
                etms[n] = (k == eff - 1);
                n++;
                if (ir) exp[k] = (k < 5) ? ir_cap[k] : data[k - 5];
                else    exp[k] = data[k];
            end
            etms[n] = 1'b1; n++;
            etms[n] = 1'b0; n++;
        end
        exp_q.push_back(exp);

        wait_ready("cmd_ready");
        start       = tms_q.size();
        i_cmd_ir    = ir;
        i_cmd_reset = rst;
        i_cmd_len   = len;
        i_cmd_data  = data;
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        chk("ready_drop", o_cmd_ready, 0);
        if (!rst && eff == 0) chk("len0_rsp_latency", o_rsp_valid, 1);

        for (int i = 0; i < 3000 && !o_rsp_valid; i++) step();
        chk("rsp_valid_wait", o_rsp_valid, 1);
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                step();
                chk("stall_valid", o_rsp_valid, 1);
                chk("stall_data", o_rsp_data, exp_q[0]);
                chk("stall_cmd_ready", o_cmd_ready, 0);
            end
        end
        got = o_rsp_data;
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        chk("rsp_done_valid", o_rsp_valid, 0);
        chk("rsp_done_ready", o_cmd_ready, 1);
        chk("rsp_data", got, exp_q.pop_front());
        chk("pulses", tms_q.size() - start, n);
        chk("tms_seq", pack_bits(1'b0, start), etms);
        chk("tdi_seq", pack_bits(1'b1, start), etdi);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int f0;
        int start;

        reset = 1'b1;
        repeat (3) step();
        chk("rst_tck", o_tck, 0);
        chk("rst_tms", o_tms, 1);
        chk("rst_tdi", o_tdi, 0);
        chk("rst_trstn", o_trstn, 0);
        chk("rst_cmd_ready", o_cmd_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        t0 = tms_q.size();
        f0 = fall_q.size();
        reset = 1'b0;
        step();
        chk("init_trstn", o_trstn, 1);
        chk("init_ready_low", o_cmd_ready, 0);
        wait_ready("init_ready");
        check_init("init", t0, f0);
        chk("dbg_idle", o_dbg_state, ST_IDLE);

        run_cmd(1'b0, 1'b0, 6'd8,  32'h0000_00A5, 1'b0);
        run_cmd(1'b1, 1'b0, 6'd5,  32'h0000_001F, 1'b0);
        run_cmd(1'b0, 1'b0, 6'd32, 32'hDEAD_BEEF, 1'b0);
        run_cmd(1'b0, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b0);
        run_cmd(1'b0, 1'b0, 6'd16, 32'h1234_5678, 1'b1);
        run_cmd(1'b0, 1'b1, 6'd8,  32'hFFFF_FFFF, 1'b0);
        for (int r = 0; r < 4; r++)
            run_cmd(1'b0, 1'b0, 6'($urandom_range(1, 32)), $urandom, 1'b0);
        run_cmd(1'b1, 1'b0, 6'd9,  $urandom, 1'b0);
        run_cmd(1'b0, 1'b0, 6'd40, $urandom, 1'b0);

        // Abort a DR scan with reset during its sixth pulse.
        wait_ready("mid_ready");
        start       = tms_q.size();
        i_cmd_ir    = 1'b0;
        i_cmd_reset = 1'b0;
        i_cmd_len   = 6'd8;
        i_cmd_data  = 32'h0000_003C;
        i_cmd_valid = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 500 && tms_q.size() < start + 6; i++) step();
        chk("mid_pulse6", tms_q.size() - start, 6);
        reset = 1'b1;
        step();
        chk("mid_tck", o_tck, 0);
        chk("mid_tms", o_tms, 1);
        chk("mid_rsp_valid", o_rsp_valid, 0);
        chk("mid_trstn", o_trstn, 0);
        chk("mid_cmd_ready", o_cmd_ready, 0);
        t0 = tms_q.size();
        f0 = fall_q.size();
        reset = 1'b0;
        step();
        chk("reinit_trstn", o_trstn, 1);
        wait_ready("reinit_ready");
        chk("reinit_no_rsp", o_rsp_valid, 0);
        check_init("reinit", t0, f0);

        run_cmd(1'b0, 1'b0, 6'd12, 32'h0000_0ABC, 1'b0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
